matrix_inverter_gj: RTL and testbench
=====================================

MATRIX_INVERTER_GJ -- requirements
Module: matrix_inverter_gj

Interface
REQ-001 Parameters SHALL be (name, default, meaning): DATA_W, 16, signed fixed-point element width.
REQ-002 FRAC_W, 8, fractional bits, so the default format is Q8.8 and 1.0 = 0x0100.
REQ-003 N_MAX, 8, largest supported order; OW = $clog2(N_MAX+1).
REQ-004 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, reset; asynchronous and active-high.
- start, in, 1, one-cycle request to begin a new inversion.
- order, in, OW, matrix order n, sampled on the cycle start is accepted.
- in_valid, in, 1, in_data is valid.
- in_ready, out, 1, block accepts input.
- in_data, in, DATA_W, element of A, row-major.
- out_valid, out, 1, out_data is valid.
- out_ready, in, 1, sink accepts output.
- out_data, out, DATA_W, element of inv(A), row-major.
- busy, out, 1, high in every state except IDLE.
- done, out, 1, one-cycle completion pulse.
- singular, out, 1, result flag; valid from the done pulse until the next accepted start.

Function
REQ-005 States SHALL be IDLE, LOAD, PIVOT, SWAP, NORM, ELIM, OUT.
REQ-006 In IDLE, start with 1 <= order <= N_MAX SHALL latch n and go to LOAD.
REQ-007 In IDLE, start with an illegal order (0 or > N_MAX) SHALL pulse done with singular=1 next cycle, stay in IDLE, and accept no data.
REQ-008 start SHALL be ignored outside IDLE.
REQ-009 LOAD: in_ready=1; each in_valid&in_ready beat SHALL write A[r][c] and set I[r][c] = (r==c) ? 1.0 : 0.
- Indices wrap c, then r.
- After beat n*n, go to PIVOT with column k=0.
REQ-010 PIVOT SHALL scan rows k..n-1, one row per cycle, keeping the row p with the largest |A[r][k]|.
- Strictly greater replaces the candidate, so ties keep the lower index.
REQ-011 If the maximum found is 0, the block SHALL pulse done with singular=1 and return to IDLE without entering OUT; otherwise go to SWAP.
REQ-012 SWAP (1 cycle) SHALL exchange rows k and p of both A and I; p==k is a no-op.
REQ-013 NORM (1 cycle) SHALL replace each element x of row k (A and I) with (x <<< FRAC_W) / pivot.
- Signed division, truncated toward zero.
- Dividend width DATA_W+FRAC_W; result truncated to DATA_W (two's-complement wrap).
REQ-014 ELIM SHALL process one row r != k per cycle, in ascending order: x[r][j] -= (A[r][k]*x[k][j]) >>> FRAC_W.
- Applies to both A and I.
- Product is 2*DATA_W signed, arithmetic shift, result wraps to DATA_W.
- The factor A[r][k] is sampled before the row update.
REQ-015 After ELIM (or directly after NORM when n==1): if k<n-1, set k+1 and go to PIVOT; else go to OUT.
REQ-016 Compute latency, from the cycle after the last input beat to the first out_valid, SHALL be exactly 3n(n+1)/2 cycles for a nonsingular matrix (n=2 gives 9).
REQ-017 OUT SHALL present I row-major with out_valid=1.
- Advance only on out_valid&out_ready.
- out_data SHALL hold stable while out_ready=0.
- After beat n*n: pulse done with singular=0 and go to IDLE.
REQ-018 in_ready SHALL be 0 outside LOAD, and out_valid SHALL be 0 outside OUT.
REQ-019 Entries outside the active n x n region SHALL be neither read nor output.

Reset
REQ-020 rst SHALL asynchronously force the following, in any state including mid-LOAD, mid-ELIM and mid-OUT:
- State IDLE.
- in_ready=0, out_valid=0, out_data=0, busy=0, done=0, singular=0.
- All counters 0.
REQ-021 Matrix storage need not be cleared by reset; the next LOAD SHALL fully define the active region.
REQ-022 After rst deasserts, the first start SHALL be honoured on the first clock edge.

Verification
REQ-023 n=2, A=[0x0100,0,0,0x0100] -> output 0x0100,0,0,0x0100; singular=0; first out_valid 9 cycles after the last input beat.
REQ-024 n=2, A=[0x0200,0,0,0x0400] -> output 0x0080,0,0,0x0040.
REQ-025 n=2, A=[0,0x0100,0x0100,0] (pivot swap required) -> output 0,0x0100,0x0100,0.
REQ-026 n=2, A=[0x0100,0x0200,0x0200,0x0400] -> done with singular=1, out_valid never asserted; start with order=0 -> done with singular=1 one cycle later, in_ready stays 0.
REQ-027 n=3 identity with out_ready toggling 1,0,0,1 -> out_data stable through each stall; exactly 9 beats.
REQ-028 rst asserted during ELIM, then a fresh n=1 run with A=[0x0400] -> output 0x0040, singular=0.

Source files
------------

// File: rtl/matrix_inverter_gj.sv
// matrix_inverter_gj
//   Gauss-Jordan inversion of an n x n signed fixed-point matrix (QI.F with
//   FRAC_W fractional bits) using partial pivoting. A is streamed in
//   row-major order, reduced in place alongside an identity matrix I, and
//   I (now inv(A)) is streamed out row-major.
// Ports
//   clk, rst         : rising-edge clock, asynchronous active-high reset
//   start, order     : begin an inversion of order n (1..N_MAX)
//   in_valid/in_ready/in_data    : element stream of A
//   out_valid/out_ready/out_data : element stream of inv(A)
//   busy             : high whenever not idle
//   done, singular   : completion pulse and result flag
module matrix_inverter_gj #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int N_MAX  = 8,
  localparam int OW    = $clog2(N_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [OW-1:0]     order,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic              singular
);

  localparam int IW = (N_MAX > 1) ? $clog2(N_MAX) : 1;
  localparam logic signed [DATA_W-1:0] ONE = DATA_W'(1) << FRAC_W;

  typedef enum logic [2:0] {IDLE, LOAD, PIVOT, SWAP, NORM, ELIM, OUT} state_t;

  state_t              state;
  logic [IW-1:0]       n_m1, k, pr, p, ec, lr, lc, orow, ocol, er;
  logic [DATA_W:0]     best, cur_abs, max_abs;
  logic                take;
  logic signed [DATA_W-1:0] a  [N_MAX][N_MAX];
  logic signed [DATA_W-1:0] im [N_MAX][N_MAX];
  logic signed [DATA_W-1:0] piv, fac;

  function automatic logic [DATA_W:0] abs_v(input logic signed [DATA_W-1:0] x);
    logic signed [DATA_W:0] xe;
    xe = {x[DATA_W-1], x};
    return xe[DATA_W] ? unsigned'(-xe) : unsigned'(xe);
  endfunction

  function automatic logic signed [DATA_W-1:0] div_q(input logic signed [DATA_W-1:0] x,
                                                     input logic signed [DATA_W-1:0] d);
    logic signed [DATA_W+FRAC_W-1:0] num, den, q;
    num = {x, {FRAC_W{1'b0}}};
    den = {{FRAC_W{d[DATA_W-1]}}, d};
    q   = num / den;
    return q[DATA_W-1:0];
  endfunction

  function automatic logic signed [DATA_W-1:0] mul_sh(input logic signed [DATA_W-1:0] f,
                                                      input logic signed [DATA_W-1:0] x);
    logic signed [2*DATA_W-1:0] fe, xe, pe;
    fe = {{DATA_W{f[DATA_W-1]}}, f};
    xe = {{DATA_W{x[DATA_W-1]}}, x};
    pe = (fe * xe) >>> FRAC_W;
    return pe[DATA_W-1:0];
  endfunction

  // Rows other than k are visited in ascending order: ec counts eliminations,
  // and skipping row k is just a +1 once ec reaches it.
  always_comb begin
    er      = (ec < k) ? ec : ec + IW'(1);
    piv     = a[k][k];
    fac     = a[er][k];
    cur_abs = abs_v(a[pr][k]);
    take    = (pr == k) || (cur_abs > best);
    max_abs = take ? cur_abs : best;
  end

  assign out_data = out_valid ? im[orow][ocol] : '0;

  // Matrix storage is not reset; LOAD defines the whole active region.
  always_ff @(posedge clk) begin
    case (state)
      LOAD: if (in_valid && in_ready) begin
        a[lr][lc]  <= in_data;
        im[lr][lc] <= (lr == lc) ? ONE : '0;
      end
      SWAP: if (p != k) begin
        for (int unsigned j = 0; j < N_MAX; j++) begin
          if (j <= 32'(n_m1)) begin
            a[k][IW'(j)]  <= a[p][IW'(j)];
            a[p][IW'(j)]  <= a[k][IW'(j)];
            im[k][IW'(j)] <= im[p][IW'(j)];
            im[p][IW'(j)] <= im[k][IW'(j)];
          end
        end
      end
      NORM: for (int unsigned j = 0; j < N_MAX; j++) begin
        if (j <= 32'(n_m1)) begin
          a[k][IW'(j)]  <= div_q(a[k][IW'(j)], piv);
          im[k][IW'(j)] <= div_q(im[k][IW'(j)], piv);
        end
      end
      ELIM: for (int unsigned j = 0; j < N_MAX; j++) begin
        if (j <= 32'(n_m1)) begin
          a[er][IW'(j)]  <= a[er][IW'(j)]  - mul_sh(fac, a[k][IW'(j)]);
          im[er][IW'(j)] <= im[er][IW'(j)] - mul_sh(fac, im[k][IW'(j)]);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      n_m1      <= '0;
      k         <= '0;
      pr        <= '0;
      p         <= '0;
      ec        <= '0;
      lr        <= '0;
      lc        <= '0;
      orow      <= '0;
      ocol      <= '0;
      best      <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      singular  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (order != '0 && order <= OW'(N_MAX)) begin
            n_m1     <= IW'(order - OW'(1));
            lr       <= '0;
            lc       <= '0;
            singular <= 1'b0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= LOAD;
          end else begin
            done     <= 1'b1;
            singular <= 1'b1;
          end
        end
        LOAD: if (in_valid) begin
          if (lc == n_m1) begin
            lc <= '0;
            if (lr == n_m1) begin
              in_ready <= 1'b0;
              k        <= '0;
              pr       <= '0;
              state    <= PIVOT;
            end else begin
              lr <= lr + IW'(1);
            end
          end else begin
            lc <= lc + IW'(1);
          end
        end
        PIVOT: begin
          if (take) begin
            best <= cur_abs;
            p    <= pr;
          end
          if (pr == n_m1) begin
            if (max_abs == '0) begin
              done     <= 1'b1;
              singular <= 1'b1;
              busy     <= 1'b0;
              state    <= IDLE;
            end else begin
              state <= SWAP;
            end
          end else begin
            pr <= pr + IW'(1);
          end
        end
        SWAP: state <= NORM;
        NORM, ELIM: begin
          if (state == NORM && n_m1 != '0) begin
            ec    <= '0;
            state <= ELIM;
          end else if (state == ELIM && ec != n_m1 - IW'(1)) begin
            ec <= ec + IW'(1);
          end else if (k == n_m1) begin
            orow      <= '0;
            ocol      <= '0;
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            k     <= k + IW'(1);
            pr    <= k + IW'(1);
            state <= PIVOT;
          end
        end
        OUT: if (out_ready) begin
          if (ocol == n_m1) begin
            ocol <= '0;
            if (orow == n_m1) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              singular  <= 1'b0;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              orow <= orow + IW'(1);
            end
          end else begin
            ocol <= ocol + IW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_inverter_gj.sv
// tb_matrix_inverter_gj
//   Directed, table-driven bench for matrix_inverter_gj with hand-computed
//   Q8.8 inverses, plus sequences for illegal order, output stalls and
//   reset during elimination.
module tb_matrix_inverter_gj;
  localparam int DW = 16;
  localparam int OW = 4;
  localparam logic [15:0] Z = 16'h0000;
  localparam logic [15:0] O = 16'h0100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [OW-1:0] order = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          busy, done, singular;

  matrix_inverter_gj #(.DATA_W(16), .FRAC_W(8), .N_MAX(8)) dut (
    .clk(clk), .rst(rst), .start(start), .order(order),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .singular(singular)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          n;
    logic [15:0] a [9];
    logic [15:0] e [9];
    bit          sing;
    int          lat;
    bit          stall;
  } vec_t;

  vec_t v [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string nm);
    check({nm, "_in_ready"}, 32'(in_ready), 0);
    check({nm, "_out_valid"}, 32'(out_valid), 0);
    check({nm, "_out_data"}, 32'(out_data), 0);
    check({nm, "_busy"}, 32'(busy), 0);
    check({nm, "_done"}, 32'(done), 0);
    check({nm, "_singular"}, 32'(singular), 0);
  endtask

  task automatic feed(input vec_t t);
    start = 1'b1;
    order = OW'(t.n);
    tick();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 1);
    check("in_ready_load", 32'(in_ready), 1);
    for (int i = 0; i < t.n * t.n; i++) begin
      in_valid = 1'b1;
      in_data  = t.a[i];
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input int idx);
    vec_t        t;
    int          cyc;
    int          beat;
    int          s;
    logic [3:0]  pat;
    t   = v[idx];
    pat = 4'b1001;
    feed(t);
    check("in_ready_after_load", 32'(in_ready), 0);
    cyc = 0;
    while (!out_valid && !done && cyc < 500) begin
      tick();
      cyc++;
    end
    if (t.sing) begin
      check("sing_done", 32'(done), 1);
      check("sing_flag", 32'(singular), 1);
      check("sing_no_out_valid", 32'(out_valid), 0);
      tick();
      check("sing_done_pulse", 32'(done), 0);
      check("sing_flag_held", 32'(singular), 1);
    end else begin
      check("latency", 32'(cyc), 32'(t.lat));
      beat = 0;
      s    = 0;
      while (beat < t.n * t.n && s < 400) begin
        out_ready = t.stall ? pat[s % 4] : 1'b1;
        if (!out_valid) begin
          check("out_valid_mid_out", 32'(out_valid), 1);
          break;
        end
        check($sformatf("v%0d_out%0d", idx, beat), 32'(out_data), 32'(t.e[beat]));
        tick();
        if (out_ready) beat++;
        s++;
      end
      out_ready = 1'b0;
      check("beats", 32'(beat), 32'(t.n * t.n));
      check("done_pulse", 32'(done), 1);
      check("done_singular", 32'(singular), 0);
      check("out_valid_after", 32'(out_valid), 0);
      tick();
      check("done_cleared", 32'(done), 0);
      check("busy_cleared", 32'(busy), 0);
    end
  endtask

  initial begin
    // n=2 identity
    v[0].n = 2; v[0].sing = 0; v[0].lat = 9; v[0].stall = 0;
    v[0].a = '{O, Z, Z, O, Z, Z, Z, Z, Z};
    v[0].e = '{O, Z, Z, O, Z, Z, Z, Z, Z};
    // n=2 diagonal 2,4
    v[1].n = 2; v[1].sing = 0; v[1].lat = 9; v[1].stall = 0;
    v[1].a = '{16'h0200, Z, Z, 16'h0400, Z, Z, Z, Z, Z};
    v[1].e = '{16'h0080, Z, Z, 16'h0040, Z, Z, Z, Z, Z};
    // n=2 anti-diagonal, needs a row swap
    v[2].n = 2; v[2].sing = 0; v[2].lat = 9; v[2].stall = 0;
    v[2].a = '{Z, O, O, Z, Z, Z, Z, Z, Z};
    v[2].e = '{Z, O, O, Z, Z, Z, Z, Z, Z};
    // n=2 [[2,1],[1,1]] -> [[1,-1],[-1,2]]
    v[3].n = 2; v[3].sing = 0; v[3].lat = 9; v[3].stall = 0;
    v[3].a = '{16'h0200, O, O, O, Z, Z, Z, Z, Z};
    v[3].e = '{O, 16'hFF00, 16'hFF00, 16'h0200, Z, Z, Z, Z, Z};
    // n=2 singular
    v[4].n = 2; v[4].sing = 1; v[4].lat = 0; v[4].stall = 0;
    v[4].a = '{O, 16'h0200, 16'h0200, 16'h0400, Z, Z, Z, Z, Z};
    v[4].e = '{Z, Z, Z, Z, Z, Z, Z, Z, Z};
    // n=3 identity with output stalls
    v[5].n = 3; v[5].sing = 0; v[5].lat = 18; v[5].stall = 1;
    v[5].a = '{O, Z, Z, Z, O, Z, Z, Z, O};
    v[5].e = '{O, Z, Z, Z, O, Z, Z, Z, O};
    // n=1 [4.0] -> 0.25
    v[6].n = 1; v[6].sing = 0; v[6].lat = 3; v[6].stall = 0;
    v[6].a = '{16'h0400, Z, Z, Z, Z, Z, Z, Z, Z};
    v[6].e = '{16'h0040, Z, Z, Z, Z, Z, Z, Z, Z};

    #12;
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(i);

    // illegal orders: 0 and N_MAX+1
    for (int i = 0; i < 2; i++) begin
      start    = 1'b1;
      order    = (i == 0) ? OW'(0) : OW'(9);
      in_valid = 1'b1;
      tick();
      start = 1'b0;
      check("illegal_done", 32'(done), 1);
      check("illegal_singular", 32'(singular), 1);
      check("illegal_in_ready", 32'(in_ready), 0);
      check("illegal_busy", 32'(busy), 0);
      tick();
      check("illegal_done_pulse", 32'(done), 0);
      check("illegal_in_ready_later", 32'(in_ready), 0);
      in_valid = 1'b0;
    end

    // reset asserted while in ELIM (edges: PIVOT, PIVOT, SWAP, NORM)
    feed(v[3]);
    repeat (4) tick();
    check("busy_in_elim", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    run_vec(6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
